ofifo_deskew: RTL
=================

OFIFO_DESKEW -- requirements
Module: ofifo_deskew

Interface
REQ-001 SHALL have parameter col, default 8: number of array columns, one lane each.
REQ-002 SHALL have parameter bw, default 16: psum width per column, in bits.
REQ-003 SHALL have parameter depth, default 64: entries per lane, a power of two.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port wr, input, col bits: per-lane write strobe; bit i writes lane i.
REQ-007 SHALL have port in, input, col*bw bits: lane i data on in[(i+1)*bw-1:i*bw].
REQ-008 SHALL have port rd, input, 1 bit: request to pop one full row from all lanes.
REQ-009 SHALL have port out, output, col*bw bits: last popped row; lane i on out[(i+1)*bw-1:i*bw].
REQ-010 SHALL have port o_valid, output, 1 bit: every lane holds at least one entry.
REQ-011 SHALL have port o_full, output, 1 bit: at least one lane is full.
REQ-012 SHALL have port o_ready, output, 1 bit: equals ~o_full.
REQ-013 SHALL have port o_ovf, output, 1 bit: sticky flag set when a write was dropped.

Function
REQ-014 Collects staggered per-column outputs (column i valid one cycle after column i-1) and releases them as aligned rows.
REQ-015 Each lane SHALL be an independent FIFO with its own wr/rd pointers of log2(depth)+1 bits; the MSB distinguishes full from empty on wrap.
REQ-016 Lane i write: wr[i]=1 and lane i not full -> store the lane slice of in at wptr and increment wptr, in the same edge.
REQ-017 A write to a full lane SHALL be dropped, SHALL set o_ovf, and SHALL NOT change that lane. This holds even when rd is accepted in the same cycle.
REQ-018 o_valid SHALL be the AND of all lane non-empty flags, computed combinationally from registered pointers.
REQ-019 A rd is accepted only when rd=1 and o_valid=1. An accepted rd pops all lanes in the same edge.
REQ-020 After an accepted rd, out SHALL show the popped row starting from the next edge (1-cycle latency), and out is registered.
REQ-021 A rd with o_valid=0 SHALL be ignored: no pointer change and out holds its value.
REQ-022 A write and an accepted rd on a non-full lane in the same cycle SHALL both take effect; the lane count is unchanged.
REQ-023 A lane that is empty at the start of a cycle SHALL NOT forward its incoming write to out in that cycle (no bypass).
REQ-024 o_full SHALL be the OR of all lane full flags; o_ready = ~o_full.
REQ-025 Back-to-back accepted rds SHALL deliver one row per cycle, in write order per lane.

Reset
REQ-026 reset=0 SHALL asynchronously clear all pointers, clear out to 0 and clear o_ovf to 0, giving o_valid=0, o_full=0, o_ready=1.
REQ-027 Memory contents are not reset; they are unobservable until written.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries; rd/wr during reset are ignored.
REQ-029 Operation resumes on the first rising edge after reset returns to 1.

Structure
REQ-030 Pointer width (log2(depth)+1) and default col/bw/depth SHALL be constants in the shared project package.
REQ-031 One sub-module, ofifo_lane (single-lane FIFO with full/empty, async active-low reset), SHALL be instantiated col times in a generate loop.
REQ-032 Row-level valid/read logic, the out register and the o_ovf register SHALL live in ofifo_deskew.

Verification
REQ-033 Staggered fill: wr bit i asserted at cycle i for i=0..7 with lane data 0x0010+i -> o_valid rises only after the lane-7 write; rd -> next cycle out = {0x0017..0x0010}.
REQ-034 Ignored read: rd=1 while lane 7 is empty -> out and pointers unchanged, o_valid=0.
REQ-035 Full and overflow: 64 writes to lane 3 only -> o_full=1, o_ready=0; 65th write dropped, o_ovf=1, lane 3 still holds writes 1..64.
REQ-036 Wrap-around: fill all lanes with 64 rows, read 40, write 40 more, read 64 -> rows emerge in order, each lane's pointers wrap correctly, and o_valid ends at 0.
REQ-037 Simultaneous write/read: every lane holds 1 entry, wr=all ones and rd=1 in the same cycle -> old row out next cycle, o_valid stays 1, count stays 1.
REQ-038 Async reset: assert reset mid-stream between edges -> outputs cleared immediately, without waiting for a clock edge; after release a fresh staggered fill behaves as in REQ-033.

Source files
------------

// File: rtl/ofifo_deskew_pkg.sv
// Shared constants for the output-FIFO deskew block.
//   ColDef   : default number of array columns (one lane each)
//   BwDef    : default psum width per column
//   DepthDef : default entries per lane (power of two)
//   PtrWDef  : pointer width for the default depth (address bits + wrap bit)
package ofifo_deskew_pkg;

  localparam int unsigned ColDef   = 8;
  localparam int unsigned BwDef    = 16;
  localparam int unsigned DepthDef = 64;
  localparam int unsigned PtrWDef  = $clog2(DepthDef) + 1;

  // Pointer width for an arbitrary depth; the extra MSB separates full from empty.
  function automatic int unsigned ptr_w(input int unsigned d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/ofifo_lane.sv
// Single-lane FIFO used once per array column.
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset, clears pointers only
//   i_wr    : write strobe, ignored when the lane is full
//   i_rd    : pop strobe, ignored when the lane is empty
//   i_data  : write data
//   o_data  : head-of-lane data (valid only when not empty)
//   o_empty : lane holds no entries
//   o_full  : lane holds depth entries
module ofifo_lane
  import ofifo_deskew_pkg::*;
#(
  parameter int unsigned bw    = BwDef,
  parameter int unsigned depth = DepthDef
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr,
  input  logic          i_rd,
  input  logic [bw-1:0] i_data,
  output logic [bw-1:0] o_data,
  output logic          o_empty,
  output logic          o_full
);

  localparam int unsigned PtrW  = ptr_w(depth);
  localparam int unsigned AddrW = PtrW - 1;

  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [bw-1:0]   r_mem [depth];
  logic            w_push;
  logic            w_pop;

  assign o_empty = (r_wptr == r_rptr);
  // Same address, different lap: writer is a full lap ahead of the reader.
  assign o_full  = (r_wptr[AddrW] != r_rptr[AddrW]) &&
                   (r_wptr[AddrW-1:0] == r_rptr[AddrW-1:0]);

  // Fullness is taken before any same-cycle pop, so a write to a full lane is
  // always dropped even if the row is being read out on the same edge.
  assign w_push = i_wr & ~o_full;
  assign w_pop  = i_rd & ~o_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
    end
  end

  // Storage is not reset; entries are only observable after being written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AddrW-1:0]] <= i_data;
  end

  assign o_data = r_mem[r_rptr[AddrW-1:0]];

endmodule

// File: rtl/ofifo_deskew.sv
// Collects staggered per-column psums into per-lane FIFOs and releases them
// as aligned rows once every lane holds at least one entry.
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset
//   wr      : per-lane write strobes, bit i writes lane i
//   in      : lane i data on in[(i+1)*bw-1:i*bw]
//   rd      : pop one row from all lanes (accepted only when o_valid)
//   out     : last popped row, registered, lane i on out[(i+1)*bw-1:i*bw]
//   o_valid : every lane non-empty
//   o_full  : at least one lane full
//   o_ready : ~o_full
//   o_ovf   : sticky, a write hit a full lane and was dropped
module ofifo_deskew
  import ofifo_deskew_pkg::*;
#(
  parameter int unsigned col   = ColDef,
  parameter int unsigned bw    = BwDef,
  parameter int unsigned depth = DepthDef
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [col-1:0]    wr,
  input  logic [col*bw-1:0] in,
  input  logic              rd,
  output logic [col*bw-1:0] out,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_ovf
);

  logic [col-1:0]    w_empty;
  logic [col-1:0]    w_full;
  logic [col*bw-1:0] w_head;
  logic              w_rd_acc;
  logic              w_drop;
  logic [col*bw-1:0] r_out;
  logic              r_ovf;

  // Flags come straight from registered pointers, so a write landing this
  // cycle never makes o_valid true (and never bypasses into out) until next.
  assign o_valid  = ~|w_empty;
  assign o_full   = |w_full;
  assign o_ready  = ~o_full;
  assign w_rd_acc = rd & o_valid;
  assign w_drop   = |(wr & w_full);

  for (genvar g = 0; g < col; g++) begin : g_lane
    ofifo_lane #(
      .bw    (bw),
      .depth (depth)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_wr    (wr[g]),
      .i_rd    (w_rd_acc),
      .i_data  (in[g*bw +: bw]),
      .o_data  (w_head[g*bw +: bw]),
      .o_empty (w_empty[g]),
      .o_full  (w_full[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_rd_acc) r_out <= w_head;
      if (w_drop)   r_ovf <= 1'b1;
    end
  end

  assign out   = r_out;
  assign o_ovf = r_ovf;

endmodule
